// File: rtl/cal_pkg.sv
// Shared calibration types: sweep FSM state encoding and the LED ID width helper.
// Also used by the calibration table and HDMI reader.
package cal_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SHOW = 3'd1,
        SETTLE    = 3'd2,
        SCAN      = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } cal_seq_state_t;

    localparam int DEFAULT_LED_ADDRESS_WIDTH = 6;
    localparam int DEFAULT_ID_W              = DEFAULT_LED_ADDRESS_WIDTH + 1;

    // One extra bit beyond the LED address so ID 0 can mean "no LED seen".
    function automatic int id_width(input int led_address_width);
        return led_address_width + 1;
    endfunction

endpackage

// File: rtl/cal_rmw_pipe.sv
// Two-stage delay line turning an issued scan address into a calibration table write
// two cycles later: OR the frame-buffer bit for the current plane into the old entry.
module cal_rmw_pipe
    import cal_pkg::*;
#(
    parameter int ID_W = DEFAULT_ID_W,
    parameter int AW   = 16,
    parameter int PW   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_addr,
    input  logic            fb_data,
    input  logic [ID_W-1:0] tbl_rdata,
    input  logic [PW-1:0]   plane,
    output logic            tbl_we,
    output logic [AW-1:0]   tbl_waddr,
    output logic [ID_W-1:0] tbl_wdata
);

    logic            v1, v2;
    logic [AW-1:0]   a1, a2;
    logic            bit2;
    logic [ID_W-1:0] base;
    logic [ID_W-1:0] plane_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            a1   <= '0;
            a2   <= '0;
            bit2 <= 1'b0;
        end else begin
            v1   <= issue_valid && !flush;
            v2   <= v1 && !flush;
            a1   <= issue_addr;
            a2   <= a1;
            // fb_data answers the read issued one cycle earlier; hold it one more
            // cycle so it lines up with the latency-2 table read.
            bit2 <= fb_data;
        end
    end

    always_comb begin
        // Plane 0 overwrites whatever the table held, so no clear pass is needed.
        base      = (plane == '0) ? '0 : tbl_rdata;
        plane_bit = ID_W'(bit2) << plane;
        tbl_we    = v2;
        tbl_waddr = v2 ? a2 : '0;
        tbl_wdata = v2 ? (base | plane_bit) : '0;
    end

endmodule

// File: rtl/cal_sequencer.sv
// LED calibration sweep controller: per bit-plane, advance the ID shower, wait for the
// strand and a settle period, then scan the frame buffer into the calibration table.
module cal_sequencer
    import cal_pkg::*;
#(
    parameter int NUM_LEDS                = 50,
    parameter int LED_ADDRESS_WIDTH       = 6,
    parameter int NUM_FRAME_BUFFER_PIXELS = 360 * 180,
    parameter int SETTLE_FRAMES           = 4,
    localparam int ID_W = id_width(LED_ADDRESS_WIDTH),
    localparam int AW   = (NUM_FRAME_BUFFER_PIXELS > 1) ? $clog2(NUM_FRAME_BUFFER_PIXELS) : 1,
    localparam int PW   = (ID_W > 1) ? $clog2(ID_W) : 1,
    localparam int FW   = $clog2(SETTLE_FRAMES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic            id_restart,
    output logic            increment_id,
    input  logic            displayed_frame_valid,
    input  logic            frame_done,
    output logic [AW-1:0]   fb_addr,
    input  logic            fb_data,
    output logic [AW-1:0]   tbl_addr,
    input  logic [ID_W-1:0] tbl_rdata,
    output logic [ID_W-1:0] tbl_wdata,
    output logic            tbl_we,
    output logic [AW-1:0]   tbl_waddr,
    output logic            busy,
    output logic            done,
    output logic [PW-1:0]   plane,
    output cal_seq_state_t  dbg_state
);

    if (NUM_LEDS > (1 << ID_W) || SETTLE_FRAMES < 1) begin : g_bad_params
        $error("cal_sequencer: NUM_LEDS does not fit the ID width or SETTLE_FRAMES < 1");
    end

    cal_seq_state_t state, state_d;
    logic [PW-1:0]  plane_d;
    logic [AW-1:0]  addr, addr_d;
    logic [FW-1:0]  fcnt, fcnt_d;
    logic           dcnt, dcnt_d;
    logic           id_restart_d, increment_id_d;
    logic           issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            plane        <= '0;
            addr         <= '0;
            fcnt         <= '0;
            dcnt         <= 1'b0;
            id_restart   <= 1'b0;
            increment_id <= 1'b0;
        end else begin
            state        <= state_d;
            plane        <= plane_d;
            addr         <= addr_d;
            fcnt         <= fcnt_d;
            dcnt         <= dcnt_d;
            id_restart   <= id_restart_d;
            increment_id <= increment_id_d;
        end
    end

    always_comb begin
        state_d        = state;
        plane_d        = plane;
        addr_d         = addr;
        fcnt_d         = fcnt;
        dcnt_d         = dcnt;
        id_restart_d   = 1'b0;
        increment_id_d = 1'b0;
        issue          = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    plane_d      = '0;
                    id_restart_d = 1'b1;
                    state_d      = WAIT_SHOW;
                end
            end
            WAIT_SHOW: begin
                if (displayed_frame_valid) begin
                    fcnt_d  = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (frame_done) begin
                    if (fcnt == FW'(SETTLE_FRAMES - 1)) begin
                        addr_d  = '0;
                        state_d = SCAN;
                    end else begin
                        fcnt_d = fcnt + FW'(1);
                    end
                end
            end
            SCAN: begin
                issue = 1'b1;
                if (addr == AW'(NUM_FRAME_BUFFER_PIXELS - 1)) begin
                    addr_d  = '0;
                    dcnt_d  = 1'b0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr + AW'(1);
                end
            end
            DRAIN: begin
                if (dcnt) begin
                    if (plane == PW'(ID_W - 1)) begin
                        state_d = DONE;
                    end else begin
                        plane_d        = plane + PW'(1);
                        increment_id_d = 1'b1;
                        state_d        = WAIT_SHOW;
                    end
                end else begin
                    dcnt_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // abort outranks everything, including a start seen in the same IDLE cycle.
        if (abort) begin
            state_d        = IDLE;
            plane_d        = '0;
            addr_d         = '0;
            id_restart_d   = 1'b0;
            increment_id_d = 1'b0;
        end
    end

    assign fb_addr   = addr;
    assign tbl_addr  = addr;
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    cal_rmw_pipe #(
        .ID_W (ID_W),
        .AW   (AW),
        .PW   (PW)
    ) u_rmw_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (abort),
        .issue_valid (issue),
        .issue_addr  (addr),
        .fb_data     (fb_data),
        .tbl_rdata   (tbl_rdata),
        .plane       (plane),
        .tbl_we      (tbl_we),
        .tbl_waddr   (tbl_waddr),
        .tbl_wdata   (tbl_wdata)
    );

endmodule

// File: tb/tb_cal_sequencer.sv
// Directed bench for cal_sequencer with behavioural frame buffer (latency 1) and
// calibration table (read latency 2) models; 3 planes, 16 pixels, settle of 2 frames.
module tb_cal_sequencer;
    import cal_pkg::*;

    localparam int LAW  = 2;
    localparam int N    = 16;
    localparam int SF   = 2;
    localparam int ID_W = 3;
    localparam int AW   = 4;
    localparam int PW   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            id_restart, increment_id;
    logic            displayed_frame_valid = 1'b0;
    logic            frame_done = 1'b0;
    logic [AW-1:0]   fb_addr;
    logic            fb_data = 1'b0;
    logic [AW-1:0]   tbl_addr;
    logic [ID_W-1:0] tbl_rdata = '0;
    logic [ID_W-1:0] tbl_wdata;
    logic            tbl_we;
    logic [AW-1:0]   tbl_waddr;
    logic            busy, done;
    logic [PW-1:0]   plane;
    cal_seq_state_t  dbg_state;

    int checks = 0;
    int failures = 0;
    int n_restart, n_incr, n_done, n_we;
    logic [ID_W-1:0] exp_q[$];

    logic            fb_mem [N];
    logic [ID_W-1:0] tbl_mem [N];
    logic [ID_W-1:0] rd1 = '0;

    cal_sequencer #(
        .NUM_LEDS                (4),
        .LED_ADDRESS_WIDTH       (LAW),
        .NUM_FRAME_BUFFER_PIXELS (N),
        .SETTLE_FRAMES           (SF)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .abort                 (abort),
        .id_restart            (id_restart),
        .increment_id          (increment_id),
        .displayed_frame_valid (displayed_frame_valid),
        .frame_done            (frame_done),
        .fb_addr               (fb_addr),
        .fb_data               (fb_data),
        .tbl_addr              (tbl_addr),
        .tbl_rdata             (tbl_rdata),
        .tbl_wdata             (tbl_wdata),
        .tbl_we                (tbl_we),
        .tbl_waddr             (tbl_waddr),
        .busy                  (busy),
        .done                  (done),
        .plane                 (plane),
        .dbg_state             (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // memory models
    always @(posedge clk) begin
        fb_data   <= fb_mem[fb_addr];
        rd1       <= tbl_mem[tbl_addr];
        tbl_rdata <= rd1;
        if (tbl_we) tbl_mem[tbl_waddr] <= tbl_wdata;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        if (id_restart)   n_restart++;
        if (increment_id) n_incr++;
        if (done)         n_done++;
        if (tbl_we)       n_we++;
    endtask

    task automatic clear_counts();
        n_restart = 0;
        n_incr    = 0;
        n_done    = 0;
        n_we      = 0;
    endtask

    task automatic load_fb(input int k);
        for (int p = 0; p < N; p++) fb_mem[p] = 1'(((p % 8) >> k) & 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Returns in the first SCAN cycle (address 0 on the bus).
    task automatic drive_plane(input int k);
        load_fb(k);
        displayed_frame_valid = 1'b1;
        tick();
        displayed_frame_valid = 1'b0;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    // tests
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({id_restart, increment_id, busy, done, tbl_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {id_restart, increment_id, busy, done, tbl_we});
        end
        checks++;
        if ({fb_addr, tbl_addr, tbl_waddr} !== 12'h0) begin
            failures++;
            $display("FAIL reset_addrs got=%h exp=000", {fb_addr, tbl_addr, tbl_waddr});
        end
        checks++;
        if (tbl_wdata !== 3'd0 || plane !== 2'd0) begin
            failures++;
            $display("FAIL reset_wdata_plane got=%0d/%0d exp=0/0", tbl_wdata, plane);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_release got=%b/%0d exp=0/%0d", busy, dbg_state, IDLE);
        end
    endtask

    task automatic test_reset_mid_scan();
        do_start();
        drive_plane(0);
        repeat (N + 2) tick();
        drive_plane(1);
        repeat (5) tick();
        checks++;
        if (plane !== 2'd1 || tbl_we !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midscan_pre got=%0d/%b/%b exp=1/1/1", plane, tbl_we, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({id_restart, increment_id, busy, done, tbl_we} !== 5'b0) begin
            failures++;
            $display("FAIL midscan_flags got=%b exp=00000", {id_restart, increment_id, busy, done, tbl_we});
        end
        checks++;
        if ({fb_addr, tbl_addr, tbl_waddr} !== 12'h0 || tbl_wdata !== 3'd0) begin
            failures++;
            $display("FAIL midscan_buses got=%h/%0d exp=000/0", {fb_addr, tbl_addr, tbl_waddr}, tbl_wdata);
        end
        checks++;
        if (plane !== 2'd0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL midscan_plane_state got=%0d/%0d exp=0/%0d", plane, dbg_state, IDLE);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_sweep();
        logic [ID_W-1:0] exp_w;
        for (int p = 0; p < N; p++) begin
            tbl_mem[p] = 3'($urandom_range(0, 7));
            exp_q.push_back(3'(p % 8));
        end
        clear_counts();
        do_start();
        checks++;
        if (id_restart !== 1'b1 || busy !== 1'b1 || dbg_state !== WAIT_SHOW) begin
            failures++;
            $display("FAIL sweep_start got=%b/%b/%0d exp=1/1/%0d", id_restart, busy, dbg_state, WAIT_SHOW);
        end
        for (int k = 0; k < ID_W; k++) begin
            drive_plane(k);
            checks++;
            if (dbg_state !== SCAN || fb_addr !== 4'd0) begin
                failures++;
                $display("FAIL sweep_scan_entry plane=%0d got=%0d/%0d exp=%0d/0", k, dbg_state, fb_addr, SCAN);
            end
            for (int i = 0; i < N + 2; i++) begin
                checks++;
                if (tbl_we !== (i >= 2)) begin
                    failures++;
                    $display("FAIL sweep_we plane=%0d cyc=%0d got=%b exp=%b", k, i, tbl_we, (i >= 2));
                end
                if (i >= 2) begin
                    exp_w = 3'(((i - 2) % 8) & ((1 << (k + 1)) - 1));
                    checks++;
                    if (tbl_waddr !== 4'(i - 2) || tbl_wdata !== exp_w) begin
                        failures++;
                        $display("FAIL sweep_write plane=%0d got=addr %0d data %0d exp=addr %0d data %0d",
                                 k, tbl_waddr, tbl_wdata, i - 2, exp_w);
                    end
                end
                tick();
            end
            if (k < ID_W - 1) begin
                checks++;
                if (increment_id !== 1'b1 || dbg_state !== WAIT_SHOW || plane !== 2'(k + 1)) begin
                    failures++;
                    $display("FAIL sweep_next_plane got=%b/%0d/%0d exp=1/%0d/%0d",
                             increment_id, dbg_state, plane, WAIT_SHOW, k + 1);
                end
            end else begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || dbg_state !== DONE) begin
                    failures++;
                    $display("FAIL sweep_done got=%b/%b/%0d exp=1/0/%0d", done, busy, dbg_state, DONE);
                end
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL sweep_idle got=%b/%0d exp=0/%0d", done, dbg_state, IDLE);
        end
        for (int p = 0; p < N; p++) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (tbl_mem[p] !== exp_w) begin
                failures++;
                $display("FAIL sweep_table p=%0d got=%0d exp=%0d", p, tbl_mem[p], exp_w);
            end
        end
        checks++;
        if (n_done !== 1 || n_incr !== 2 || n_restart !== 1) begin
            failures++;
            $display("FAIL sweep_pulse_counts got=%0d/%0d/%0d exp=1/2/1", n_done, n_incr, n_restart);
        end
    endtask

    task automatic test_stale_plane0();
        for (int p = 0; p < N; p++) tbl_mem[p] = 3'd7;
        do_start();
        drive_plane(0);
        repeat (N + 2) tick();
        for (int p = 0; p < N; p++) begin
            checks++;
            if (tbl_mem[p] !== 3'(p & 1)) begin
                failures++;
                $display("FAIL stale_plane0 p=%0d got=%0d exp=%0d", p, tbl_mem[p], p & 1);
            end
        end
        do_abort();
    endtask

    task automatic test_settle_timing();
        do_start();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        checks++;
        if (dbg_state !== WAIT_SHOW) begin
            failures++;
            $display("FAIL settle_early_frames got=%0d exp=%0d", dbg_state, WAIT_SHOW);
        end
        load_fb(0);
        displayed_frame_valid = 1'b1;
        tick();
        displayed_frame_valid = 1'b0;
        checks++;
        if (dbg_state !== SETTLE) begin
            failures++;
            $display("FAIL settle_entry got=%0d exp=%0d", dbg_state, SETTLE);
        end
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        displayed_frame_valid = 1'b1;
        tick();
        displayed_frame_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (dbg_state !== SETTLE) begin
            failures++;
            $display("FAIL settle_after_one got=%0d exp=%0d", dbg_state, SETTLE);
        end
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        checks++;
        if (dbg_state !== SCAN || fb_addr !== 4'd0 || tbl_addr !== 4'd0 || tbl_we !== 1'b0) begin
            failures++;
            $display("FAIL settle_scan_start got=%0d/%0d/%0d/%b exp=%0d/0/0/0",
                     dbg_state, fb_addr, tbl_addr, tbl_we, SCAN);
        end
        tick();
        checks++;
        if (fb_addr !== 4'd1 || tbl_we !== 1'b0) begin
            failures++;
            $display("FAIL settle_scan_1 got=%0d/%b exp=1/0", fb_addr, tbl_we);
        end
        tick();
        checks++;
        if (fb_addr !== 4'd2 || tbl_we !== 1'b1 || tbl_waddr !== 4'd0) begin
            failures++;
            $display("FAIL settle_first_write got=%0d/%b/%0d exp=2/1/0", fb_addr, tbl_we, tbl_waddr);
        end
        do_abort();
    endtask

    task automatic test_abort();
        do_start();
        drive_plane(0);
        repeat (N + 2) tick();
        drive_plane(1);
        repeat (5) tick();
        checks++;
        if (fb_addr !== 4'd5 || tbl_we !== 1'b1 || plane !== 2'd1) begin
            failures++;
            $display("FAIL abort_pre got=%0d/%b/%0d exp=5/1/1", fb_addr, tbl_we, plane);
        end
        clear_counts();
        do_abort();
        checks++;
        if (tbl_we !== 1'b0 || busy !== 1'b0 || plane !== 2'd0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL abort_next got=%b/%b/%0d/%0d exp=0/0/0/%0d", tbl_we, busy, plane, dbg_state, IDLE);
        end
        checks++;
        if (fb_addr !== 4'd0) begin
            failures++;
            $display("FAIL abort_addr got=%0d exp=0", fb_addr);
        end
        repeat (4) tick();
        checks++;
        if (n_we !== 0 || n_done !== 0 || n_incr !== 0) begin
            failures++;
            $display("FAIL abort_quiet got=%0d/%0d/%0d exp=0/0/0", n_we, n_done, n_incr);
        end
    endtask

    task automatic test_start_held();
        clear_counts();
        start = 1'b1;
        tick();
        checks++;
        if (id_restart !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL held_start got=%b/%b exp=1/1", id_restart, busy);
        end
        for (int k = 0; k < ID_W; k++) begin
            drive_plane(k);
            repeat (N + 2) tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || n_restart !== 1) begin
            failures++;
            $display("FAIL held_done got=%b/%b/%0d exp=1/0/1", done, busy, n_restart);
        end
        tick();
        checks++;
        if (dbg_state !== IDLE || id_restart !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL held_idle got=%0d/%b/%b exp=%0d/0/0", dbg_state, id_restart, busy, IDLE);
        end
        tick();
        checks++;
        if (dbg_state !== WAIT_SHOW || id_restart !== 1'b1 || busy !== 1'b1 || plane !== 2'd0) begin
            failures++;
            $display("FAIL held_restart got=%0d/%b/%b/%0d exp=%0d/1/1/0",
                     dbg_state, id_restart, busy, plane, WAIT_SHOW);
        end
        checks++;
        if (n_restart !== 2 || n_done !== 1 || n_incr !== 2) begin
            failures++;
            $display("FAIL held_counts got=%0d/%0d/%0d exp=2/1/2", n_restart, n_done, n_incr);
        end
        start = 1'b0;
        do_abort();
    endtask

    task automatic test_abort_start_idle();
        clear_counts();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (dbg_state !== IDLE || busy !== 1'b0 || id_restart !== 1'b0) begin
            failures++;
            $display("FAIL abort_wins got=%0d/%b/%b exp=%0d/0/0", dbg_state, busy, id_restart, IDLE);
        end
        repeat (2) tick();
        checks++;
        if (dbg_state !== IDLE || n_restart !== 0) begin
            failures++;
            $display("FAIL abort_wins_later got=%0d/%0d exp=%0d/0", dbg_state, n_restart, IDLE);
        end
    endtask

    initial begin
        for (int p = 0; p < N; p++) begin
            fb_mem[p]  = 1'b0;
            tbl_mem[p] = '0;
        end
        clear_counts();
        test_reset();
        test_reset_mid_scan();
        test_full_sweep();
        test_stale_plane0();
        test_settle_timing();
        test_abort();
        test_start_held();
        test_abort_start_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
